// File: rtl/median7_pkg.sv
// Shared definitions for the 7x7 median sort scheduler.
//   PIX_W_DEF : default pixel width
//   WIN       : window edge length (7)
//   phase_e   : scheduler phase encoding
//   pix_idx   : flat row-major index of pixel (r,c) inside the window bus
package median7_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int WIN       = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    COL  = 3'd1,
    ROW  = 3'd2,
    DIAG = 3'd3,
    OUT  = 3'd4
  } phase_e;

  function automatic int unsigned pix_idx(input int unsigned r, input int unsigned c);
    return r * WIN + c;
  endfunction

endpackage

// File: rtl/median7_win_regfile.sv
// 7x7 pixel register file with a phase-selected 7-lane read mux and a
// column/row write port.
//   clk, rst    : clock, async active-high reset (clears every pixel)
//   load_i      : capture the whole window from win_i
//   win_i       : row-major window, pixel (r,c) at pix_idx(r,c)*PIX_W
//   wr_en_i     : write wr_data_i into one row (wr_row_i=1) or column
//   wr_idx_i    : row/column being written; lane 0 lands at column/row 0
//   rd_sel_i    : COL -> column, ROW -> row, DIAG -> anti-diagonal
//   rd_idx_i    : column/row being read (ignored for DIAG)
//   rd_data_o   : 7 lanes, lane 0 in the LSBs
// The read mux sees a pending write in the same cycle, so the scheduler can
// issue the first sort of a phase on the edge that stores the last result of
// the previous phase.
module median7_win_regfile
  import median7_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic [WIN*WIN*PIX_W-1:0] win_i,
  input  logic                     wr_en_i,
  input  logic                     wr_row_i,
  input  logic [2:0]               wr_idx_i,
  input  logic [WIN*PIX_W-1:0]     wr_data_i,
  input  phase_e                   rd_sel_i,
  input  logic [2:0]               rd_idx_i,
  output logic [WIN*PIX_W-1:0]     rd_data_o
);

  logic [PIX_W-1:0] mem_q [WIN][WIN];
  logic [PIX_W-1:0] fwd_s [WIN][WIN];

  // Register file contents with this cycle's write applied.
  always_comb begin
    fwd_s = mem_q;
    if (wr_en_i) begin
      for (int k = 0; k < WIN; k++) begin
        if (wr_row_i) begin
          fwd_s[wr_idx_i][k] = wr_data_i[k*PIX_W +: PIX_W];
        end else begin
          fwd_s[k][wr_idx_i] = wr_data_i[k*PIX_W +: PIX_W];
        end
      end
    end else begin
      fwd_s = mem_q;
    end
  end

  // Read mux: anti-diagonal lane 0 is pixel (0,6).
  always_comb begin
    rd_data_o = '0;
    case (rd_sel_i)
      COL:  for (int k = 0; k < WIN; k++) rd_data_o[k*PIX_W +: PIX_W] = fwd_s[k][rd_idx_i];
      ROW:  for (int k = 0; k < WIN; k++) rd_data_o[k*PIX_W +: PIX_W] = fwd_s[rd_idx_i][k];
      DIAG: for (int k = 0; k < WIN; k++) rd_data_o[k*PIX_W +: PIX_W] = fwd_s[k][WIN-1-k];
      default: rd_data_o = '0;
    endcase
  end

  // Storage: window load has priority over write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++) mem_q[r][c] <= '0;
    end else if (load_i) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++) mem_q[r][c] <= win_i[pix_idx(r, c)*PIX_W +: PIX_W];
    end else begin
      mem_q <= fwd_s;
    end
  end

endmodule

// File: rtl/median7x7_sort_scheduler.sv
// Approximate 7x7 median: drives one shared external 7-input sorter through
// 7 column sorts, 7 row sorts and 1 anti-diagonal sort, writing results back
// in place; the anti-diagonal mid value is the median.
//   clk, rst      : clock, async active-high reset
//   done_i/win_i  : window handshake, sampled while ready_o=1
//   ready_o       : high only in IDLE
//   done_o        : one-cycle pulse, median_o valid (held until next pulse)
//   srt_done_o    : one pulse per issued sort, srt_S_o carries S1..S7
//   srt_done_i    : sorter result strobe, srt_sorted_i ascending, min in LSBs
module median7x7_sort_scheduler
  import median7_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int SORT_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_i,
  input  logic [WIN*WIN*PIX_W-1:0] win_i,
  output logic                     ready_o,
  output logic                     done_o,
  output logic [PIX_W-1:0]         median_o,
  output logic                     srt_done_o,
  output logic [WIN*PIX_W-1:0]     srt_S_o,
  input  logic                     srt_done_i,
  input  logic [WIN*PIX_W-1:0]     srt_sorted_i
);

  if (SORT_LAT < 1 || SORT_LAT > 15) begin : g_lat_check
    $error("SORT_LAT must be in 1..15");
  end

  phase_e                 state_q, state_d;
  logic [2:0]             ic_q, ic_d, rc_q, rc_d;
  logic                   ready_q, ready_d, done_q, done_d;
  logic [PIX_W-1:0]       median_q, median_d;
  logic                   srt_done_q, srt_done_d;
  logic [WIN*PIX_W-1:0]   srt_s_q, srt_s_d;

  logic                   load_s, wr_en_s, wr_row_s, issue_s;
  logic [2:0]             wr_idx_s, rd_idx_s;
  phase_e                 rd_sel_s;
  logic [WIN*PIX_W-1:0]   rd_data_s;

  median7_win_regfile #(.PIX_W(PIX_W)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_s),
    .win_i     (win_i),
    .wr_en_i   (wr_en_s),
    .wr_row_i  (wr_row_s),
    .wr_idx_i  (wr_idx_s),
    .wr_data_i (srt_sorted_i),
    .rd_sel_i  (rd_sel_s),
    .rd_idx_i  (rd_idx_s),
    .rd_data_o (rd_data_s)
  );

  // Next-state, counters, regfile control and sorter issue.
  always_comb begin
    state_d    = state_q;
    ic_d       = ic_q;
    rc_d       = rc_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    median_d   = median_q;
    srt_done_d = 1'b0;
    srt_s_d    = srt_s_q;
    load_s     = 1'b0;
    wr_en_s    = 1'b0;
    wr_row_s   = (state_q == ROW);
    wr_idx_s   = rc_q;
    rd_sel_s   = state_q;
    rd_idx_s   = ic_q;
    issue_s    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (done_i) begin
          load_s  = 1'b1;
          ready_d = 1'b0;
          ic_d    = 3'd0;
          rc_d    = 3'd0;
          state_d = COL;
        end else begin
          state_d = IDLE;
        end
      end
      COL, ROW: begin
        issue_s = (ic_q < 3'd7);
        if (issue_s) ic_d = ic_q + 3'd1;
        else         ic_d = ic_q;
        if (srt_done_i && (rc_q < 3'd7)) begin
          wr_en_s = 1'b1;
          rc_d    = rc_q + 3'd1;
          // Last result of the phase: issue the next phase's first sort on
          // the same edge, reading through the regfile write forwarding.
          if (rc_q == 3'd6) begin
            rc_d     = 3'd0;
            rd_idx_s = 3'd0;
            issue_s  = 1'b1;
            if (state_q == COL) begin
              state_d  = ROW;
              rd_sel_s = ROW;
              ic_d     = 3'd1;
            end else begin
              state_d  = DIAG;
              rd_sel_s = DIAG;
              ic_d     = 3'd0;
            end
          end else begin
            state_d = state_q;
          end
        end else begin
          rc_d = rc_q;
        end
      end
      DIAG: begin
        if (srt_done_i) begin
          median_d = srt_sorted_i[3*PIX_W +: PIX_W];
          done_d   = 1'b1;
          state_d  = OUT;
        end else begin
          state_d = DIAG;
        end
      end
      OUT: begin
        ready_d = 1'b1;
        ic_d    = 3'd0;
        rc_d    = 3'd0;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (issue_s) begin
      srt_done_d = 1'b1;
      srt_s_d    = rd_data_s;
    end else begin
      srt_done_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ic_q       <= 3'd0;
      rc_q       <= 3'd0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      median_q   <= '0;
      srt_done_q <= 1'b0;
      srt_s_q    <= '0;
    end else begin
      state_q    <= state_d;
      ic_q       <= ic_d;
      rc_q       <= rc_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      median_q   <= median_d;
      srt_done_q <= srt_done_d;
      srt_s_q    <= srt_s_d;
    end
  end

  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign median_o   = median_q;
  assign srt_done_o = srt_done_q;
  assign srt_S_o    = srt_s_q;

endmodule

// File: tb/tb_median7x7_sort_scheduler.sv
module tb_median7x7_sort_scheduler;

  localparam int PW = 8;
  localparam int L  = 3;
  localparam int EXP_LAT = 16 + 3 * L;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            done_i = 1'b0;
  logic [391:0]    win_i = '0;
  logic            ready_o, done_o, srt_done_o, srt_done_i;
  logic [PW-1:0]   median_o;
  logic [55:0]     srt_S_o, srt_sorted_i;

  int n_checks = 0;
  int n_pass   = 0;

  median7x7_sort_scheduler #(.PIX_W(PW), .SORT_LAT(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .done_i       (done_i),
    .win_i        (win_i),
    .ready_o      (ready_o),
    .done_o       (done_o),
    .median_o     (median_o),
    .srt_done_o   (srt_done_o),
    .srt_S_o      (srt_S_o),
    .srt_done_i   (srt_done_i),
    .srt_sorted_i (srt_sorted_i)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] sort7(input logic [55:0] s);
    int a[7];
    int t;
    logic [55:0] o;
    for (int i = 0; i < 7; i++) a[i] = int'(s[i*8 +: 8]);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 6 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 7; i++) o[i*8 +: 8] = a[i][7:0];
    return o;
  endfunction

  // Behavioural sorter: fixed latency L, results in issue order.
  logic        pv [L];
  logic [55:0] pd [L];
  logic        stray = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
    end else begin
      pv[0] <= srt_done_o;
      pd[0] <= sort7(srt_S_o);
      for (int i = 1; i < L; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
    end
  end

  assign srt_done_i   = pv[L-1] | stray;
  assign srt_sorted_i = pd[L-1];

  // Issue monitor: count sorter issues and remember the last issued inputs.
  int          n_issue = 0;
  logic [55:0] last_s  = '0;
  always @(negedge clk) begin
    if (srt_done_o) begin
      n_issue <= n_issue + 1;
      last_s  <= srt_S_o;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference: sort every column, then every row, then the anti-diagonal.
  task automatic ref_model(input logic [391:0] w, output logic [7:0] med, output logic [55:0] dg);
    int m[7][7];
    logic [55:0] v, s;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) m[r][c] = int'(w[(7*r+c)*8 +: 8]);
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 7; r++) v[r*8 +: 8] = m[r][c][7:0];
      s = sort7(v);
      for (int r = 0; r < 7; r++) m[r][c] = int'(s[r*8 +: 8]);
    end
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 7; c++) v[c*8 +: 8] = m[r][c][7:0];
      s = sort7(v);
      for (int c = 0; c < 7; c++) m[r][c] = int'(s[c*8 +: 8]);
    end
    for (int r = 0; r < 7; r++) dg[r*8 +: 8] = m[r][6-r][7:0];
    s   = sort7(dg);
    med = s[31:24];
  endtask

  task automatic wait_done(output int k);
    k = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (done_o) begin k = i; break; end
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !ready_o; i++) begin @(posedge clk); #1; end
    check_eq("ready_wait", ready_o, 1'b1);
  endtask

  task automatic run_txn(input string tag, input logic [391:0] w);
    logic [7:0]  em;
    logic [55:0] ed;
    int k, n0;
    ref_model(w, em, ed);
    wait_ready();
    @(negedge clk);
    win_i = w; done_i = 1'b1; n0 = n_issue;
    @(posedge clk); #1;
    done_i = 1'b0;
    check_eq({tag, "_ready_drop"}, ready_o, 1'b0);
    wait_done(k);
    check_eq({tag, "_latency"}, k, EXP_LAT);
    check_eq({tag, "_median"}, median_o, em);
    check_eq({tag, "_issues"}, n_issue - n0, 15);
    check_eq({tag, "_diag_s"}, last_s, ed);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, done_o, 1'b0);
    check_eq({tag, "_ready_back"}, ready_o, 1'b1);
    check_eq({tag, "_median_hold"}, median_o, em);
  endtask

  logic [391:0] w, wb;
  logic [7:0]   em_a, em_b;
  logic [55:0]  ed;
  int           k;

  initial begin
    #12 rst = 1'b0;
    #1;
    check_eq("rst_ready", ready_o, 1'b1);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_median", median_o, 8'd0);
    check_eq("rst_srt_done", srt_done_o, 1'b0);
    check_eq("rst_srt_s", srt_S_o, 56'd0);

    for (int i = 0; i < 49; i++) w[i*8 +: 8] = 8'd77;
    run_txn("flat77", w);
    for (int i = 0; i < 49; i++) w[i*8 +: 8] = 8'(i);
    run_txn("ramp", w);
    for (int i = 0; i < 49; i++) w[i*8 +: 8] = 8'(48 - i);
    run_txn("ramp_rev", w);
    for (int i = 0; i < 49; i++) w[i*8 +: 8] = 8'd10;
    w[24*8 +: 8] = 8'd255;
    w[7:0]       = 8'd0;
    run_txn("outlier", w);

    // Reset during ROW, then a stray sorter strobe in IDLE.
    for (int i = 0; i < 49; i++) w[i*8 +: 8] = 8'($urandom_range(255, 1));
    wait_ready();
    @(negedge clk); win_i = w; done_i = 1'b1;
    @(posedge clk); #1; done_i = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("abort_ready", ready_o, 1'b1);
    check_eq("abort_done", done_o, 1'b0);
    check_eq("abort_median", median_o, 8'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done_o || !ready_o || srt_done_o) k++;
    end
    check_eq("stray_ignored", k, 0);
    check_eq("stray_median", median_o, 8'd0);
    run_txn("after_abort", w);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 49; i++) w[i*8 +: 8] = 8'($urandom);
      run_txn($sformatf("rand%0d", t), w);
    end

    // done_i held high with a changing window.
    for (int i = 0; i < 49; i++) begin w[i*8 +: 8] = 8'($urandom); wb[i*8 +: 8] = 8'($urandom); end
    ref_model(w, em_a, ed);
    ref_model(wb, em_b, ed);
    wait_ready();
    @(negedge clk); win_i = w; done_i = 1'b1;
    @(posedge clk); #1;
    k = -1;
    for (int i = 1; i <= 80; i++) begin
      win_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      if (done_o) begin k = i; break; end
    end
    check_eq("hold_latency_a", k, EXP_LAT);
    check_eq("hold_median_a", median_o, em_a);
    win_i = wb;
    @(posedge clk); #1;
    check_eq("hold_ready_gap", ready_o, 1'b1);
    @(posedge clk); #1;
    check_eq("hold_accept_b", ready_o, 1'b0);
    done_i = 1'b0;
    wait_done(k);
    check_eq("hold_latency_b", k, EXP_LAT);
    check_eq("hold_median_b", median_o, em_b);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
